mac_dot_sequencer: RTL and testbench

Upstream controller for the mac_128 accumulator. It accepts a dot-product command (vector length 1..128) and consumes a valid/ready stream of operand pairs. It drives the MAC's a/b/acc_rst inputs and zeroes operands on bubbles, because the MAC accumulates every clock. After the last pair it waits out the MAC latency, captures the accumulator, and presents the result on a valid/ready output.

---
 rtl/mac_dot_sequencer_pkg.sv | 15 +
 rtl/mac_dot_sequencer_if.sv | 32 +++
 rtl/mac_dot_sequencer.sv | 111 +++++++++++
 tb/tb_mac_dot_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_dot_sequencer_pkg.sv
// Shared widths and state encoding for the mac_128 dot-product sequencer.
package mac_dot_sequencer_pkg;

    localparam int unsigned IN_WIDTH   = 16;
    localparam int unsigned COUNT_BITS = 7;
    localparam int unsigned ACC_WIDTH  = 2 * IN_WIDTH + COUNT_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Command, operand stream, MAC drive and result signals of the dot-product sequencer.
interface mac_dot_sequencer_if
    import mac_dot_sequencer_pkg::*;
    ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [COUNT_BITS-1:0] cmd_len;
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_WIDTH-1:0]   in_a;
    logic [IN_WIDTH-1:0]   in_b;
    logic [IN_WIDTH-1:0]   mac_a;
    logic [IN_WIDTH-1:0]   mac_b;
    logic                  mac_acc_rst;
    logic [ACC_WIDTH-1:0]  mac_acc;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  res_data;
    logic                  busy;

    modport master (
        input  cmd_valid, cmd_len, in_valid, in_a, in_b, mac_acc, out_ready,
        output cmd_ready, in_ready, mac_a, mac_b, mac_acc_rst, out_valid, res_data, busy
    );

    modport slave (
        output cmd_valid, cmd_len, in_valid, in_a, in_b, mac_acc, out_ready,
        input  cmd_ready, in_ready, mac_a, mac_b, mac_acc_rst, out_valid, res_data, busy
    );

endinterface

// File: rtl/mac_dot_sequencer.sv
// Feeds operand pairs into an always-accumulating MAC, zeroing bubbles, then
// waits out the MAC latency and presents the accumulated dot product.
module mac_dot_sequencer
    import mac_dot_sequencer_pkg::*;
#(
    parameter int unsigned MAC_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    mac_dot_sequencer_if.master bus
);

    localparam int unsigned DRAIN_BITS = $clog2(MAC_LAT + 1) + 1;
    localparam logic [DRAIN_BITS-1:0] DRAIN_LAST = DRAIN_BITS'(MAC_LAT);

    state_t                state_q, state_d;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic [COUNT_BITS-1:0] len_q, len_d;
    logic [DRAIN_BITS-1:0] drain_q, drain_d;
    logic [IN_WIDTH-1:0]   a_q, a_d;
    logic [IN_WIDTH-1:0]   b_q, b_d;
    logic                  acc_rst_q, acc_rst_d;
    logic                  out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]  res_q, res_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            len_q       <= '0;
            drain_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_rst_q   <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            len_q       <= len_d;
            drain_q     <= drain_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_rst_q   <= acc_rst_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end

    // Operands default to zero every cycle: the MAC adds a*b on every edge.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        len_d       = len_q;
        drain_d     = drain_q;
        a_d         = '0;
        b_d         = '0;
        acc_rst_d   = 1'b1;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    len_d     = bus.cmd_len;
                    count_d   = '0;
                    acc_rst_d = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                acc_rst_d = 1'b0;
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    count_d = count_q + 1'b1;
                    if (count_q == len_q) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                acc_rst_d = 1'b0;
                if (drain_q == DRAIN_LAST) begin
                    res_d       = bus.mac_acc;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.in_ready    = (state_q == RUN);
    assign bus.busy        = (state_q != IDLE);
    assign bus.mac_a       = a_q;
    assign bus.mac_b       = b_q;
    assign bus.mac_acc_rst = acc_rst_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.res_data    = res_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed + randomized bench for mac_dot_sequencer driving a behavioural MAC.
module tb_mac_dot_sequencer;
    import mac_dot_sequencer_pkg::*;

    localparam int unsigned MAC_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [IN_WIDTH-1:0]  va [128];
    logic [IN_WIDTH-1:0]  vb [128];
    logic [ACC_WIDTH-1:0] acc_model = '0;

    mac_dot_sequencer_if bus ();

    mac_dot_sequencer #(.MAC_LAT(MAC_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural mac_128: accumulates every clock, one cycle of latency.
    always_ff @(posedge clk)
        acc_model <= bus.mac_acc_rst ? '0
                   : acc_model + ACC_WIDTH'(bus.mac_a) * ACC_WIDTH'(bus.mac_b);
    assign bus.mac_acc = acc_model;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random bubbles.
    task automatic do_dot(input int unsigned n, input int unsigned mode,
                          input int unsigned hold, input string tag);
        logic [ACC_WIDTH-1:0] expv;
        int unsigned i, t, k;
        bit v;
        expv = '0;
        i = 0; t = 0; k = 0;
        for (int unsigned j = 0; j < n; j++)
            expv += ACC_WIDTH'(va[j]) * ACC_WIDTH'(vb[j]);

        check({tag, "/idle_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "/idle_acc_rst"}, bus.mac_acc_rst, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = COUNT_BITS'(n - 1);
        tick();
        bus.cmd_valid = 1'b0;
        check({tag, "/run_busy"}, bus.busy, 1);
        check({tag, "/run_acc_rst"}, bus.mac_acc_rst, 0);

        while (i < n && t < 1000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (t % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.in_valid = v;
            bus.in_a = v ? va[i] : IN_WIDTH'($urandom);
            bus.in_b = v ? vb[i] : IN_WIDTH'($urandom);
            check({tag, "/in_ready"}, bus.in_ready, 1);
            tick();
            t++;
            if (v) begin
                check({tag, "/mac_a"}, bus.mac_a, va[i]);
                check({tag, "/mac_b"}, bus.mac_b, vb[i]);
                i++;
            end else begin
                check({tag, "/bubble_a"}, bus.mac_a, 0);
                check({tag, "/bubble_b"}, bus.mac_b, 0);
            end
        end
        bus.in_valid = 1'b0;
        check({tag, "/pairs_taken"}, i, n);

        while (!bus.out_valid && k < 300) begin
            check({tag, "/drain_in_ready"}, bus.in_ready, 0);
            tick();
            k++;
        end
        check({tag, "/latency"}, k, MAC_LAT + 1);
        check({tag, "/out_valid"}, bus.out_valid, 1);
        check({tag, "/res_data"}, bus.res_data, expv);
        check({tag, "/done_cmd_ready"}, bus.cmd_ready, 0);

        bus.out_ready = 1'b0;
        for (int unsigned h = 0; h < hold; h++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_len   = COUNT_BITS'($urandom);
            tick();
            check({tag, "/hold_valid"}, bus.out_valid, 1);
            check({tag, "/hold_data"}, bus.res_data, expv);
            check({tag, "/hold_cmd_ready"}, bus.cmd_ready, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "/after_out_valid"}, bus.out_valid, 0);
        check({tag, "/after_busy"}, bus.busy, 0);
        check({tag, "/after_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "/after_acc_rst"}, bus.mac_acc_rst, 1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst/cmd_ready", bus.cmd_ready, 1);
        check("rst/in_ready", bus.in_ready, 0);
        check("rst/busy", bus.busy, 0);
        check("rst/acc_rst", bus.mac_acc_rst, 1);
        check("rst/mac_a", bus.mac_a, 0);
        check("rst/mac_b", bus.mac_b, 0);
        check("rst/out_valid", bus.out_valid, 0);
        check("rst/res_data", bus.res_data, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int unsigned i = 0; i < 6; i++) begin
            va[i] = IN_WIDTH'(i);
            vb[i] = IN_WIDTH'(2 * i);
        end
        do_dot(6, 0, 0, "len6");

        for (int unsigned i = 0; i < 16; i++) begin
            va[i] = IN_WIDTH'(i);
            vb[i] = IN_WIDTH'(2 * i);
        end
        do_dot(16, 0, 0, "len16");

        for (int unsigned i = 0; i < 4; i++) begin
            va[i] = 16'd3;
            vb[i] = 16'd4;
        end
        do_dot(4, 1, 0, "bubbles");

        for (int unsigned i = 0; i < 128; i++) begin
            va[i] = 16'hFFFF;
            vb[i] = 16'hFFFF;
        end
        do_dot(128, 0, 5, "max");

        // cmd_valid is still high from the hold: next command accepted on the next edge
        for (int unsigned i = 0; i < 3; i++) begin
            va[i] = IN_WIDTH'($urandom);
            vb[i] = IN_WIDTH'($urandom);
        end
        do_dot(3, 0, 0, "after_hold");

        for (int unsigned r = 0; r < 4; r++) begin
            int unsigned n;
            n = $urandom_range(1, 24);
            for (int unsigned i = 0; i < n; i++) begin
                va[i] = IN_WIDTH'($urandom);
                vb[i] = IN_WIDTH'($urandom);
            end
            do_dot(n, 2, $urandom_range(0, 3), $sformatf("rand%0d", r));
        end

        // reset in the middle of an 8-pair command
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 7'd7;
        tick();
        bus.cmd_valid = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = IN_WIDTH'($urandom_range(1, 65535));
            bus.in_b     = IN_WIDTH'($urandom_range(1, 65535));
            tick();
        end
        bus.in_valid = 1'b0;
        check("midrst/pre_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("midrst/acc_rst", bus.mac_acc_rst, 1);
        check("midrst/mac_a", bus.mac_a, 0);
        check("midrst/mac_b", bus.mac_b, 0);
        check("midrst/busy", bus.busy, 0);
        check("midrst/in_ready", bus.in_ready, 0);
        check("midrst/out_valid", bus.out_valid, 0);
        check("midrst/res_data", bus.res_data, 0);
        tick();
        rst = 1'b0;
        for (int unsigned c = 0; c < 4; c++) begin
            tick();
            check("midrst/no_out_valid", bus.out_valid, 0);
            check("midrst/idle", bus.cmd_ready, 1);
        end

        va[0] = 16'd5; vb[0] = 16'd5;
        va[1] = 16'd1; vb[1] = 16'd1;
        do_dot(2, 0, 0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
